// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared Breakout screen geometry and paddle state encoding
package breakout_pkg;

    localparam int SCREEN_W = 640;
    localparam int PADDLE_W = 64;
    localparam int X_W      = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_L = 2'd1,
        MOVE_R = 2'd2
    } paddle_state_e;

endpackage

// File: rtl/paddle_ctrl_if.sv
// rtl/paddle_ctrl_if.sv - keyboard-level inputs and paddle outputs of paddle_ctrl
interface paddle_ctrl_if #(
    parameter int X_W = breakout_pkg::X_W
);
    logic           frame_tick;
    logic           move_left;
    logic           move_right;
    logic           other_in;
    logic [3:0]     level;
    logic [X_W-1:0] paddle_x;
    logic           moving;
    logic           dir;
    logic           launch;

    modport master (
        output frame_tick, move_left, move_right, other_in, level,
        input  paddle_x, moving, dir, launch
    );

    modport slave (
        input  frame_tick, move_left, move_right, other_in, level,
        output paddle_x, moving, dir, launch
    );
endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, parameterized width
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - frame-rate paddle position with hold-to-accelerate and launch pulse
module paddle_ctrl #(
    parameter int SCREEN_W     = breakout_pkg::SCREEN_W,
    parameter int PADDLE_W     = breakout_pkg::PADDLE_W,
    parameter int X_W          = breakout_pkg::X_W,
    parameter int BASE_STEP    = 2,
    parameter int ACCEL_FRAMES = 8,
    parameter int MAX_BONUS    = 4,
    parameter int MAX_STEP     = 12
) (
    input  logic          clk,
    input  logic          rst,
    paddle_ctrl_if.slave  bus
);
    import breakout_pkg::*;

    localparam int HW = $clog2(ACCEL_FRAMES) + 1;
    localparam int BW = $clog2(MAX_BONUS) + 1;
    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - PADDLE_W);
    localparam logic [X_W-1:0] X_RST = X_W'((SCREEN_W - PADDLE_W) / 2);

    logic [2:0]     raw_keys;
    logic [2:0]     syn;
    paddle_state_e  state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [BW-1:0]  bonus_q, bonus_d;
    logic [X_W-1:0] x_q, x_d;
    logic           moving_q, moving_d;
    logic           dir_q, dir_d;
    logic           launch_q, launch_d;
    logic           other_prev_q;
    logic [4:0]     step_raw, step;
    logic [X_W:0]   sum;

    assign raw_keys = {bus.other_in, bus.move_right, bus.move_left};

    sync2 #(.WIDTH(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (raw_keys),
        .q_o (syn)
    );

    always_comb begin
        state_d = IDLE;
        if (syn[0] ^ syn[1]) begin
            state_d = syn[0] ? MOVE_L : MOVE_R;
        end

        // Counters belong to the state being entered; a tick on a change edge is not counted.
        hold_d  = hold_q;
        bonus_d = bonus_q;
        if (state_d != state_q || state_q == IDLE) begin
            hold_d  = '0;
            bonus_d = '0;
        end else if (bus.frame_tick) begin
            if (hold_q == HW'(ACCEL_FRAMES - 1)) begin
                hold_d = '0;
                if (bonus_q != BW'(MAX_BONUS)) begin
                    bonus_d = bonus_q + 1'b1;
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end

        step_raw = 5'(BASE_STEP) + {1'b0, bus.level} + 5'(bonus_q);
        step     = (step_raw > 5'(MAX_STEP)) ? 5'(MAX_STEP) : step_raw;
        sum      = {1'b0, x_q} + (X_W+1)'(step);

        x_d = x_q;
        if (bus.frame_tick) begin
            case (state_q)
                MOVE_L:  x_d = (x_q < X_W'(step)) ? '0 : x_q - X_W'(step);
                MOVE_R:  x_d = (sum > {1'b0, X_MAX}) ? X_MAX : sum[X_W-1:0];
                default: x_d = x_q;
            endcase
        end

        moving_d = (state_d != IDLE);
        dir_d    = dir_q;
        if (state_d == MOVE_R) begin
            dir_d = 1'b1;
        end else if (state_d == MOVE_L) begin
            dir_d = 1'b0;
        end

        launch_d = syn[2] & ~other_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            bonus_q      <= '0;
            x_q          <= X_RST;
            moving_q     <= 1'b0;
            dir_q        <= 1'b0;
            launch_q     <= 1'b0;
            other_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            bonus_q      <= bonus_d;
            x_q          <= x_d;
            moving_q     <= moving_d;
            dir_q        <= dir_d;
            launch_q     <= launch_d;
            other_prev_q <= syn[2];
        end
    end

    assign bus.paddle_x = x_q;
    assign bus.moving   = moving_q;
    assign bus.dir      = dir_q;
    assign bus.launch   = launch_q;
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - scoreboard bench for paddle_ctrl against a frame-level reference model
module tb_paddle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    paddle_ctrl_if bus ();

    paddle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x;
        bit mov;
        bit dr;
        bit lau;
    } exp_t;
    exp_t expq[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: keys reach the paddle two samples late; speed depends on ticks held in one direction.
    bit       started = 0;
    int       mx, mdir, mheld, stp, nd;
    bit       mdirlast, prevo, lau;
    logic [2:0] h1, h2, r_now, cur;

    always @(posedge clk) begin
        r_now = {bus.other_in, bus.move_right, bus.move_left};
        if (rst) begin
            started  = 1;
            mx       = 288;
            mdir     = 0;
            mheld    = 0;
            mdirlast = 0;
            prevo    = 0;
            h1       = '0;
            h2       = '0;
            expq.push_back('{288, 1'b0, 1'b0, 1'b0});
        end else if (started) begin
            cur = h2;
            if (bus.frame_tick && mdir != 0) begin
                stp = 2 + int'(bus.level) + (((mheld / 8) > 4) ? 4 : (mheld / 8));
                if (stp > 12) stp = 12;
                if (mdir == 1) mx = (mx < stp) ? 0 : mx - stp;
                else           mx = (mx + stp > 576) ? 576 : mx + stp;
                mheld++;
            end
            nd = (cur[0] ^ cur[1]) ? (cur[0] ? 1 : 2) : 0;
            if (nd != mdir || nd == 0) mheld = 0;
            mdir = nd;
            if (nd == 2)      mdirlast = 1;
            else if (nd == 1) mdirlast = 0;
            lau   = cur[2] & ~prevo;
            prevo = cur[2];
            h2 = h1;
            h1 = r_now;
            expq.push_back('{mx, (nd != 0), mdirlast, lau});
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("sb_paddle_x", int'(bus.paddle_x), e.x);
            chk("sb_moving", int'(bus.moving), int'(e.mov));
            chk("sb_dir", int'(bus.dir), int'(e.dr));
            chk("sb_launch", int'(bus.launch), int'(e.lau));
        end
    end

    initial begin
        int c;
        c = 0;
        bus.frame_tick = 1'b0;
        forever begin
            @(negedge clk);
            bus.frame_tick = (c == 0);
            c = (c + 1) % 10;
        end
    end

    task automatic wait_ticks(input int n);
        int budget;
        for (int i = 0; i < n; i++) begin
            budget = 0;
            do begin
                @(posedge clk);
                budget++;
            end while (!bus.frame_tick && budget < 100);
            if (budget >= 100) chk("tick_timeout", budget, 0);
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int x_before, pulses, lat;
    int r;

    initial begin
        bus.move_left  = 1'b0;
        bus.move_right = 1'b0;
        bus.other_in   = 1'b0;
        bus.level      = 4'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        wait_ticks(3);
        chk("reset_x", int'(bus.paddle_x), 288);
        chk("reset_moving", int'(bus.moving), 0);
        chk("reset_launch", int'(bus.launch), 0);
        chk("reset_dir", int'(bus.dir), 0);

        @(negedge clk);
        bus.move_right = 1'b1;
        wait_ticks(8);
        chk("right_8_ticks", int'(bus.paddle_x), 304);
        wait_ticks(1);
        chk("right_tick9_step3", int'(bus.paddle_x), 307);
        chk("right_dir", int'(bus.dir), 1);

        @(negedge clk);
        bus.level = 4'd15;
        wait_ticks(50);
        chk("right_wall", int'(bus.paddle_x), 576);
        wait_ticks(5);
        chk("right_wall_hold", int'(bus.paddle_x), 576);

        @(negedge clk);
        bus.move_right = 1'b0;
        bus.move_left  = 1'b1;
        wait_ticks(60);
        chk("left_wall", int'(bus.paddle_x), 0);
        wait_ticks(3);
        chk("left_wall_hold", int'(bus.paddle_x), 0);
        chk("left_dir", int'(bus.dir), 0);

        do_reset();
        bus.level      = 4'd0;
        bus.move_right = 1'b1;
        wait_ticks(5);
        chk("both_keys_x", int'(bus.paddle_x), 288);
        chk("both_keys_idle", int'(bus.moving), 0);

        @(negedge clk);
        bus.move_left = 1'b0;
        bus.level     = 4'd3;
        wait_ticks(20);
        x_before = int'(bus.paddle_x);
        @(negedge clk);
        bus.move_right = 1'b0;
        bus.move_left  = 1'b1;
        wait_ticks(1);
        chk("switch_step_base", x_before - int'(bus.paddle_x), 5);

        @(negedge clk);
        bus.move_left  = 1'b0;
        bus.move_right = 1'b1;
        bus.level      = 4'd1;
        wait_ticks(20);
        chk("pre_reset_moving", int'(bus.moving), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_reset_x", int'(bus.paddle_x), 288);
        chk("mid_reset_idle", int'(bus.moving), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(1);
        chk("post_reset_base_step", int'(bus.paddle_x), 291);

        @(negedge clk);
        bus.move_right = 1'b0;
        repeat (3) @(negedge clk);
        bus.other_in = 1'b1;
        pulses = 0;
        lat    = -1;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk);
            #1;
            if (bus.launch) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        chk("launch_hold_pulses", pulses, 1);
        chk("launch_latency", lat, 3);

        @(negedge clk);
        bus.other_in = 1'b0;
        repeat (5) @(negedge clk);
        bus.other_in = 1'b1;
        @(negedge clk);
        bus.other_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.launch) pulses++;
        end
        chk("glitch_at_most_one", int'(pulses <= 1), 1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = 1'b0;
            r = int'($urandom_range(0, 39));
            if (r == 0) bus.move_left  = ~bus.move_left;
            if (r == 1) bus.move_right = ~bus.move_right;
            if (r == 2) bus.other_in   = ~bus.other_in;
            if (r == 3) bus.level      = 4'($urandom);
            if (r == 4 && $urandom_range(0, 19) == 0) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
